// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexes one shared BCD-to-seven-segment decoder across DIGITS
// common-cathode digits. Each digit gets exactly SCAN_DIV clock cycles:
//   SETUP (1 cycle) : digit enables off, BCD already shows this digit's nibble,
//                     decoder result is captured into the segment register.
//   SHOW  (SCAN_DIV-1 cycles) : this digit's enable is on, segments stable.
// The segment register and the enables never change on the same edge while a
// digit is lit, so there is no ghosting between neighbouring digits.
//
// New display values arrive via a load/ready handshake into a pending
// register. The pending value is copied into the shadow register only at the
// frame boundary, so a frame is always drawn from a single value.
//
// Ports
//   clk_i        system clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   load_i       request to capture value_i (honoured only while ready_o=1)
//   value_i      packed BCD, nibble i = digit i (digit DIGITS-1 is MSD)
//   lz_blank_i   1 = suppress leading zeros (sampled in SETUP)
//   ready_o      1 = a load this cycle will be accepted
//   bcd_o        nibble presented to the shared decoder
//   seg_in_i     decoder result for bcd_o (gfedcba), combinational
//   segments_o   registered segment drive (gfedcba, active high)
//   digit_en_o   one-hot active-high digit select, or all zero
//   frame_o      one-cycle pulse during the first SETUP cycle of digit 0
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  lz_blank_i,
    output logic                  ready_o,
    output logic [3:0]            bcd_o,
    input  logic [6:0]            seg_in_i,
    output logic [6:0]            segments_o,
    output logic [DIGITS-1:0]     digit_en_o,
    output logic                  frame_o
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);

    localparam logic [0:0] ST_SETUP = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    // SHOW lasts SCAN_DIV-1 cycles; the prescaler counts 0..SCAN_DIV-2 in it.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [0:0]            state_q,    state_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [PRE_W-1:0]      pre_q,      pre_d;
    logic [4*DIGITS-1:0]   shadow_q,   shadow_d;
    logic [4*DIGITS-1:0]   pend_q,     pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [3:0]            bcd_q,      bcd_d;
    logic [6:0]            seg_q,      seg_d;
    logic [DIGITS-1:0]     en_q,       en_d;
    logic                  frame_q,    frame_d;

    logic [3:0]            shadow_nib [DIGITS];
    logic [3:0]            pend_nib   [DIGITS];
    logic [DIGITS-1:0]     zero_from;
    logic                  zero_acc;
    logic                  suppress;
    logic [IDX_W-1:0]      idx_inc;
    logic                  last_show;
    logic                  wrap;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign shadow_nib[gi] = shadow_q[4*gi +: 4];
            assign pend_nib[gi]   = pend_q[4*gi +: 4];
        end
    endgenerate

    // zero_from[i] = shadow nibbles i..DIGITS-1 are all zero.
    always_comb begin
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc && (shadow_nib[i] == 4'd0);
            zero_from[i] = zero_acc;
        end
    end

    // Digit 0 is never blanked so a zero value still shows a single "0".
    assign suppress  = lz_blank_i && (idx_q != '0) && zero_from[idx_q];
    assign idx_inc   = idx_q + 1'b1;
    assign last_show = (state_q == ST_SHOW) && (pre_q == PRE_LAST);
    assign wrap      = (idx_q == IDX_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pre_d      = pre_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bcd_d      = bcd_q;
        seg_d      = seg_q;
        en_d       = en_q;
        frame_d    = 1'b0;

        // Value is only sampled while the pending slot is free.
        if (load_i && !pend_vld_q) begin
            pend_d     = value_i;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            ST_SETUP: begin
                seg_d   = suppress ? 7'd0 : seg_in_i;
                en_d    = '0;
                en_d[idx_q] = 1'b1;
                pre_d   = '0;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (last_show) begin
                    en_d    = '0;
                    pre_d   = '0;
                    state_d = ST_SETUP;
                    if (wrap) begin
                        idx_d   = '0;
                        frame_d = 1'b1;
                        // Commit uses the registered valid, so a load accepted
                        // on this very cycle waits for the following boundary.
                        if (pend_vld_q) begin
                            shadow_d   = pend_q;
                            pend_vld_d = 1'b0;
                            bcd_d      = pend_nib[0];
                        end else begin
                            bcd_d      = shadow_nib[0];
                        end
                    end else begin
                        idx_d = idx_inc;
                        bcd_d = shadow_nib[idx_inc];
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SETUP;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_SETUP;
            idx_q      <= '0;
            pre_q      <= '0;
            shadow_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd_q      <= 4'd0;
            seg_q      <= 7'd0;
            en_q       <= '0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pre_q      <= pre_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bcd_q      <= bcd_d;
            seg_q      <= seg_d;
            en_q       <= en_d;
            frame_q    <= frame_d;
        end
    end

    assign ready_o    = ~pend_vld_q;
    assign bcd_o      = bcd_q;
    assign segments_o = seg_q;
    assign digit_en_o = en_q;
    assign frame_o    = frame_q;

endmodule
